// File: rtl/axis_pg_pkg.sv
// axis_pg_pkg: shared state type, pattern mode codes and
// pattern math for the AXI4-Stream pattern generator.
package axis_pg_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2,
      DONE = 2'd3
   } pg_state_e;

   localparam logic [1:0] MODE_CNT   = 2'd0;
   localparam logic [1:0] MODE_LFSR  = 2'd1;
   localparam logic [1:0] MODE_WALK  = 2'd2;
   localparam logic [1:0] MODE_CONST = 2'd3;

   localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

   // First pattern value of a run; an all-zero LFSR
   // would lock up, so it starts from 1 instead.
   function automatic logic [31:0] pat_init(
      input logic [1:0]  mode,
      input logic [31:0] seed
   );
      logic [31:0] p;
      case (mode)
         MODE_LFSR: p = (seed == 32'd0) ? 32'd1 : seed;
         MODE_WALK: p = 32'd1 << seed[4:0];
         default:   p = seed;
      endcase
      return p;
   endfunction

   // Pattern value after one accepted beat.
   function automatic logic [31:0] pat_step(
      input logic [1:0]  mode,
      input logic [31:0] p
   );
      logic [31:0] n;
      case (mode)
         MODE_CNT:  n = p + 32'd1;
         MODE_LFSR: n = p[0] ? ((p >> 1) ^ LFSR_POLY)
                             : (p >> 1);
         MODE_WALK: n = {p[30:0], p[31]};
         default:   n = p;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/axis_pg_pattern.sv
// axis_pg_pattern: 32-bit pattern core with load/advance
// and registered replication across the tdata lanes.
module axis_pg_pattern
   import axis_pg_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              load_i,
   input  logic              adv_i,
   input  logic [1:0]        mode_i,
   input  logic [31:0]       seed_i,
   output logic [DATA_W-1:0] data_o
);

   localparam int LANES = DATA_W / 32;

   logic [31:0]       p_q, p_d;
   logic [1:0]        mode_q, mode_d;
   logic [DATA_W-1:0] data_q, data_d;

   // Next core value; a load at run start beats advance.
   always_comb begin
      p_d    = p_q;
      mode_d = mode_q;
      if (load_i) begin
         p_d    = pat_init(mode_i, seed_i);
         mode_d = mode_i;
      end else if (adv_i) begin
         p_d = pat_step(mode_q, p_q);
      end
   end

   // Counter lanes carry consecutive values, others copy.
   always_comb begin
      data_d = '0;
      for (int i = 0; i < LANES; i++) begin
         if (mode_d == MODE_CNT)
            data_d[i*32 +: 32] = p_d + 32'(i);
         else
            data_d[i*32 +: 32] = p_d;
      end
   end

   // Core, mode and output data registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         p_q    <= '0;
         mode_q <= MODE_CNT;
         data_q <= '0;
      end else begin
         p_q    <= p_d;
         mode_q <= mode_d;
         data_q <= data_d;
      end
   end

   assign data_o = data_q;

endmodule

// File: rtl/axis_pattern_gen.sv
// axis_pattern_gen: framed AXI4-Stream test source with
// run control, packet/stall counters and status.
module axis_pattern_gen
   import axis_pg_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int LEN_W  = 16,
   parameter int CNT_W  = 16
) (
   input  logic                FCLK_CLK0,
   input  logic                rst,
   input  logic                enable,
   input  logic [1:0]          cfg_mode,
   input  logic [LEN_W-1:0]    cfg_pkt_len,
   input  logic [CNT_W-1:0]    cfg_num_pkts,
   input  logic [LEN_W-1:0]    cfg_gap,
   input  logic [31:0]         cfg_seed,
   output logic [DATA_W-1:0]   m_axis_tdata,
   output logic [DATA_W/8-1:0] m_axis_tkeep,
   output logic                m_axis_tlast,
   output logic                m_axis_tvalid,
   input  logic                m_axis_tready,
   output logic                busy,
   output logic                done,
   output logic [CNT_W-1:0]    pkt_cnt,
   output logic [31:0]         stall_cnt
);

   pg_state_e        state_q, state_d;
   logic             en_q, en_qq, start_q;
   logic [LEN_W-1:0] lenm1_q, lenm1_d;
   logic [CNT_W-1:0] num_q, num_d;
   logic [LEN_W-1:0] gap_q, gap_d;
   logic [LEN_W-1:0] beat_q, beat_d;
   logic [LEN_W-1:0] gapc_q, gapc_d;
   logic [CNT_W-1:0] pkt_q, pkt_d;
   logic [31:0]      stall_q, stall_d;
   logic             tlast_q, tlast_d;
   logic             load, adv, xfer;

   assign xfer = (state_q == SEND) & m_axis_tready;

   // Run control, beat/gap counting and counters.
   always_comb begin
      state_d = state_q;
      lenm1_d = lenm1_q;
      num_d   = num_q;
      gap_d   = gap_q;
      beat_d  = beat_q;
      gapc_d  = gapc_q;
      pkt_d   = pkt_q;
      stall_d = stall_q;
      load    = 1'b0;
      adv     = 1'b0;
      unique case (state_q)
         IDLE, DONE: begin
            if (start_q) begin
               lenm1_d = (cfg_pkt_len == '0) ? '0
                       : cfg_pkt_len - LEN_W'(1);
               num_d   = cfg_num_pkts;
               gap_d   = cfg_gap;
               beat_d  = '0;
               pkt_d   = '0;
               stall_d = '0;
               load    = 1'b1;
               state_d = SEND;
            end
         end
         SEND: begin
            if (!m_axis_tready && stall_q != '1)
               stall_d = stall_q + 32'd1;
            if (xfer) begin
               adv = 1'b1;
               if (tlast_q) begin
                  pkt_d  = pkt_q + CNT_W'(1);
                  beat_d = '0;
                  if (num_q != '0 && pkt_d == num_q) begin
                     state_d = DONE;
                  end else if (!enable) begin
                     state_d = IDLE;
                  end else if (gap_q != '0) begin
                     state_d = GAP;
                     gapc_d  = gap_q - LEN_W'(1);
                  end
               end else begin
                  beat_d = beat_q + LEN_W'(1);
               end
            end
         end
         GAP: begin
            if (gapc_q == '0)
               state_d = enable ? SEND : IDLE;
            else
               gapc_d = gapc_q - LEN_W'(1);
         end
         default: ;
      endcase
      tlast_d = (state_d == SEND) && (beat_d == lenm1_d);
   end

   // Enable edge detect and all control state.
   always_ff @(posedge FCLK_CLK0 or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         en_q    <= 1'b0;
         en_qq   <= 1'b0;
         start_q <= 1'b0;
         lenm1_q <= '0;
         num_q   <= '0;
         gap_q   <= '0;
         beat_q  <= '0;
         gapc_q  <= '0;
         pkt_q   <= '0;
         stall_q <= '0;
         tlast_q <= 1'b0;
      end else begin
         state_q <= state_d;
         en_q    <= enable;
         en_qq   <= en_q;
         start_q <= en_q & ~en_qq;
         lenm1_q <= lenm1_d;
         num_q   <= num_d;
         gap_q   <= gap_d;
         beat_q  <= beat_d;
         gapc_q  <= gapc_d;
         pkt_q   <= pkt_d;
         stall_q <= stall_d;
         tlast_q <= tlast_d;
      end
   end

   axis_pg_pattern #(
      .DATA_W (DATA_W)
   ) u_pattern (
      .clk_i  (FCLK_CLK0),
      .rst_i  (rst),
      .load_i (load),
      .adv_i  (adv),
      .mode_i (cfg_mode),
      .seed_i (cfg_seed),
      .data_o (m_axis_tdata)
   );

   assign m_axis_tkeep  = '1;
   assign m_axis_tlast  = tlast_q;
   assign m_axis_tvalid = (state_q == SEND);
   assign busy          = (state_q == SEND) ||
                          (state_q == GAP);
   assign done          = (state_q == DONE);
   assign pkt_cnt       = pkt_q;
   assign stall_cnt     = stall_q;

endmodule

// File: tb/tb_axis_pattern_gen.sv
// tb_axis_pattern_gen: directed and randomized runs checked
// against a beat-level reference model of the stream.
module tb_axis_pattern_gen;

   localparam int DATA_W = 32;
   localparam int LEN_W  = 16;
   localparam int CNT_W  = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic              enable;
   logic [1:0]        cfg_mode;
   logic [LEN_W-1:0]  cfg_pkt_len;
   logic [CNT_W-1:0]  cfg_num_pkts;
   logic [LEN_W-1:0]  cfg_gap;
   logic [31:0]       cfg_seed;
   logic [DATA_W-1:0] tdata;
   logic [3:0]        tkeep;
   logic              tlast, tvalid, tready;
   logic              busy, done;
   logic [CNT_W-1:0]  pkt_cnt;
   logic [31:0]       stall_cnt;

   always #5 clk = ~clk;

   axis_pattern_gen #(
      .DATA_W (DATA_W),
      .LEN_W  (LEN_W),
      .CNT_W  (CNT_W)
   ) dut (
      .FCLK_CLK0     (clk),
      .rst           (rst),
      .enable        (enable),
      .cfg_mode      (cfg_mode),
      .cfg_pkt_len   (cfg_pkt_len),
      .cfg_num_pkts  (cfg_num_pkts),
      .cfg_gap       (cfg_gap),
      .cfg_seed      (cfg_seed),
      .m_axis_tdata  (tdata),
      .m_axis_tkeep  (tkeep),
      .m_axis_tlast  (tlast),
      .m_axis_tvalid (tvalid),
      .m_axis_tready (tready),
      .busy          (busy),
      .done          (done),
      .pkt_cnt       (pkt_cnt),
      .stall_cnt     (stall_cnt)
   );

   int          n_tests = 0;
   int          n_fail  = 0;
   int          stall_exp;
   logic [31:0] obs_d[$];
   logic        obs_l[$];
   int          obs_t[$];

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] lfsr_next(
      input logic [31:0] p);
      if (p[0]) return (p >> 1) ^ 32'h8020_0003;
      return p >> 1;
   endfunction

   // Pattern value of beat k of a run (non-LFSR modes).
   function automatic logic [31:0] ref_pat(
      input int m, input logic [31:0] s, input int k);
      int sh;
      case (m)
         0: return s + 32'(k);
         2: begin
            sh = (int'(s[4:0]) + k) % 32;
            return 32'd1 << sh;
         end
         default: return s;
      endcase
   endfunction

   task automatic start_run(input int m, input int len,
                            input int num, input int gap,
                            input logic [31:0] seed);
      enable = 1'b0;
      repeat (3) @(negedge clk);
      cfg_mode     = 2'(m);
      cfg_pkt_len  = 16'(len);
      cfg_num_pkts = 16'(num);
      cfg_gap      = 16'(gap);
      cfg_seed     = seed;
      enable       = 1'b1;
   endtask

   // Drive tready and record accepted beats.
   // rmode: 0 always ready, 1 random, 2 toggle 1/0.
   task automatic collect(input int nb, input int rmode,
                          input int drop_at, input bit scr);
      int          cyc;
      bit          held, first;
      logic [31:0] hd;
      logic        hl;
      obs_d.delete();
      obs_l.delete();
      obs_t.delete();
      stall_exp = 0;
      cyc   = 0;
      held  = 1'b0;
      first = 1'b1;
      hd    = '0;
      hl    = 1'b0;
      while (obs_d.size() < nb && cyc < 4000) begin
         @(negedge clk);
         if (held) begin
            chk("hold_valid", 32'(tvalid), 32'd1);
            chk("hold_data", tdata, hd);
            chk("hold_last", 32'(tlast), 32'(hl));
         end
         held = 1'b0;
         case (rmode)
            0:       tready = 1'b1;
            1:       tready = 1'($urandom_range(0, 1));
            default: tready = (cyc % 2 == 0);
         endcase
         if (tvalid && first) begin
            chk("busy_run", 32'(busy), 32'd1);
            chk("done_clr", 32'(done), 32'd0);
            first = 1'b0;
         end
         if (tvalid) begin
            if (tready) begin
               obs_d.push_back(tdata);
               obs_l.push_back(tlast);
               obs_t.push_back(cyc);
               if (obs_d.size() == drop_at)
                  enable = 1'b0;
               if (scr && obs_d.size() == 1) begin
                  cfg_mode     = 2'($urandom_range(0, 3));
                  cfg_pkt_len  = 16'($urandom_range(1, 9));
                  cfg_num_pkts = 16'($urandom_range(1, 9));
                  cfg_gap      = 16'($urandom_range(1, 9));
                  cfg_seed     = $urandom;
               end
            end else begin
               stall_exp++;
               held = 1'b1;
               hd   = tdata;
               hl   = tlast;
            end
         end
         cyc++;
      end
      chk("collect_beats", 32'(obs_d.size()), 32'(nb));
   endtask

   task automatic check_run(input string tag, input int m,
                            input logic [31:0] s,
                            input int len, input int nb);
      int          L;
      logic [31:0] lf, e;
      L  = (len == 0) ? 1 : len;
      lf = (s == 0) ? 32'd1 : s;
      for (int k = 0; k < nb && k < obs_d.size(); k++) begin
         e = (m == 1) ? lf : ref_pat(m, s, k);
         chk($sformatf("%s_data%0d", tag, k), obs_d[k], e);
         chk($sformatf("%s_last%0d", tag, k),
             32'(obs_l[k]), 32'((k % L) == L - 1));
         lf = lfsr_next(lf);
      end
   endtask

   task automatic chk_done(input string tag, input int np);
      @(negedge clk);
      chk({tag, "_done"},  32'(done), 32'd1);
      chk({tag, "_valid"}, 32'(tvalid), 32'd0);
      chk({tag, "_busy"},  32'(busy), 32'd0);
      chk({tag, "_pkts"},  32'(pkt_cnt), 32'(np));
      chk({tag, "_stall"}, stall_cnt, 32'(stall_exp));
   endtask

   initial begin
      int          m, len, num, gap;
      logic [31:0] seed;
      rst          = 1'b1;
      enable       = 1'b0;
      tready       = 1'b1;
      cfg_mode     = '0;
      cfg_pkt_len  = '0;
      cfg_num_pkts = '0;
      cfg_gap      = '0;
      cfg_seed     = '0;
      #1;
      chk("rst_valid", 32'(tvalid), 32'd0);
      chk("rst_last",  32'(tlast), 32'd0);
      chk("rst_busy",  32'(busy), 32'd0);
      chk("rst_done",  32'(done), 32'd0);
      chk("rst_data",  tdata, 32'd0);
      chk("rst_pkts",  32'(pkt_cnt), 32'd0);
      chk("rst_stall", stall_cnt, 32'd0);
      chk("rst_keep",  32'(tkeep), 32'hF);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Counter, two 128-beat packets, always ready.
      start_run(0, 128, 2, 0, 32'd0);
      collect(256, 0, -1, 1'b1);
      chk("cnt_latency", 32'(obs_t[0]), 32'd2);
      chk("cnt_b2b", 32'(obs_t[128] - obs_t[127]), 32'd1);
      check_run("cnt", 0, 32'd0, 128, 256);
      chk_done("cnt", 2);

      // Same run with tready toggling.
      start_run(0, 128, 2, 0, 32'd0);
      collect(256, 2, -1, 1'b0);
      check_run("tog", 0, 32'd0, 128, 256);
      chk_done("tog", 2);

      // LFSR from a zero seed.
      start_run(1, 4, 1, 0, 32'd0);
      collect(4, 0, -1, 1'b0);
      chk("lfsr_b1", obs_d[1], 32'h8020_0003);
      check_run("lfsr", 1, 32'd0, 4, 4);
      chk_done("lfsr", 1);

      // Walking one with a 5-cycle gap.
      start_run(2, 3, 2, 5, 32'd31);
      collect(6, 0, -1, 1'b0);
      chk("walk_b0", obs_d[0], 32'h8000_0000);
      chk("walk_b2b", 32'(obs_t[1] - obs_t[0]), 32'd1);
      chk("walk_gap", 32'(obs_t[3] - obs_t[2]), 32'd6);
      check_run("walk", 2, 32'd31, 3, 6);
      chk_done("walk", 2);

      // Reset on beat 2 of the second packet.
      start_run(0, 4, 0, 0, 32'h100);
      collect(6, 0, -1, 1'b0);
      @(negedge clk);
      chk("rst_pre_valid", 32'(tvalid), 32'd1);
      chk("rst_pre_pkts", 32'(pkt_cnt), 32'd1);
      rst = 1'b1;
      #1;
      chk("rst_mid_valid", 32'(tvalid), 32'd0);
      chk("rst_mid_pkts", 32'(pkt_cnt), 32'd0);
      @(negedge clk);
      chk("rst_mid_busy", 32'(busy), 32'd0);
      enable = 1'b0;
      rst    = 1'b0;
      start_run(0, 4, 0, 0, 32'h100);
      collect(3, 0, -1, 1'b0);
      check_run("rst_again", 0, 32'h100, 4, 3);
      rst = 1'b1;
      @(negedge clk);
      rst    = 1'b0;
      enable = 1'b0;

      // Continuous run, enable dropped after beat 3.
      seed = $urandom;
      start_run(0, 8, 0, 0, seed);
      collect(8, 0, 4, 1'b0);
      check_run("drop", 0, seed, 8, 8);
      @(negedge clk);
      chk("drop_valid", 32'(tvalid), 32'd0);
      chk("drop_busy",  32'(busy), 32'd0);
      chk("drop_done",  32'(done), 32'd0);
      chk("drop_pkts",  32'(pkt_cnt), 32'd1);
      repeat (3) begin
         @(negedge clk);
         chk("drop_idle", 32'(tvalid), 32'd0);
      end

      // Random configurations under random backpressure.
      for (int r = 0; r < 6; r++) begin
         m    = int'($urandom_range(0, 3));
         len  = int'($urandom_range(0, 5));
         num  = int'($urandom_range(1, 3));
         gap  = int'($urandom_range(0, 3));
         seed = (r == 0) ? 32'd0 : $urandom;
         start_run(m, len, num, gap, seed);
         collect(((len == 0) ? 1 : len) * num, 1, -1, 1'b0);
         check_run($sformatf("rnd%0d", r), m, seed, len,
                   ((len == 0) ? 1 : len) * num);
         chk_done($sformatf("rnd%0d", r), num);
      end

      $display("[TB] %0d tests run, %0d failed",
               n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/axis_pattern_gen.md
Name: axis_pattern_gen

Overview:
Parametrised AXI4-Stream source that drives the DMA S2MM slave port with framed test traffic. Software configures it through GPIO/AXI-Lite fields:
- packet length, packet count, inter-packet gap, data pattern and seed.
- AXIS handshake is fully compliant (data held under backpressure; tlast registered).
- Status and stall counters are reported back for DMA bring-up and throughput checks.

Parameters:
DATA_W, 32, tdata width in bits; multiple of 32.
LEN_W, 16, width of packet-length and gap fields.
CNT_W, 16, width of packet-count field and counters.

Ports:
FCLK_CLK0  in  1  fabric clock.
rst  in  1  asynchronous active-high reset.
enable  in  1  run request; a rising edge starts a run.
cfg_mode  in  2  pattern: 0 counter, 1 LFSR, 2 walking-one, 3 constant seed.
cfg_pkt_len  in  LEN_W  beats per packet; 0 is treated as 1.
cfg_num_pkts  in  CNT_W  packets per run; 0 means continuous.
cfg_gap  in  LEN_W  idle cycles between packets.
cfg_seed  in  32  initial value for the counter/LFSR/constant patterns.
m_axis_tdata  out  DATA_W  stream data.
m_axis_tkeep  out  DATA_W/8  all ones.
m_axis_tlast  out  1  last beat of packet.
m_axis_tvalid  out  1  stream valid.
m_axis_tready  in  1  stream ready.
busy  out  1  high in any state other than IDLE and DONE.
done  out  1  high in DONE; cleared by the next start.
pkt_cnt  out  CNT_W  completed packets this run.
stall_cnt  out  32  cycles with tvalid=1 and tready=0; saturates.

Behaviour:
- Reset (async assert, sync release): state IDLE; tvalid, tlast, busy, done = 0; tdata, pkt_cnt, stall_cnt = 0.
- Start is a registered rising edge of enable. In IDLE or DONE, start does the following:
  - latches all cfg_* inputs; they are ignored for the rest of the run;
  - clears pkt_cnt, stall_cnt and done;
  - loads the pattern register from the seed;
  - enters SEND.
- Timing: tvalid rises 1 cycle after the start edge is detected, i.e. 2 cycles after enable is seen high.
- States:
  - IDLE -> SEND on start.
  - SEND: tvalid=1.
    - A beat transfers when tvalid and tready are both high.
    - On each transfer the beat counter increments and the pattern advances.
    - tlast=1 exactly when the beat counter equals len-1. It is registered, not derived from tdata.
    - On the tlast transfer: pkt_cnt++, beat counter -> 0. Next state:
      - DONE if num_pkts!=0 and pkt_cnt+1==num_pkts;
      - IDLE if enable=0;
      - GAP if gap!=0;
      - otherwise SEND, back-to-back with no bubble.
  - GAP: tvalid=0 for exactly gap cycles, then SEND (or IDLE if enable has dropped).
  - DONE: tvalid=0, done=1. Leaves only on the next start.
- Deasserting enable mid-packet never truncates: the current packet completes with tlast so the DMA never hangs. Then go to IDLE with done=0.
- AXIS rules:
  - tdata, tlast and tvalid are stable while tvalid=1 and tready=0.
  - tvalid never drops without a transfer, except on reset.
- Patterns (32-bit core P, replicated across DATA_W/32 lanes; lane i = P+i in counter mode, P in other modes):
  - counter: P=seed; P+=1 per transfer; wraps modulo 2^32.
  - LFSR: Galois, polynomial 0x80200003, right-shift; seed 0 is forced to 1.
  - walking-one: P = 1<<(seed[4:0]); rotate left by 1 per transfer.
  - constant: P=seed.
- The pattern continues across packet boundaries within a run. It is not reset per packet.
- stall_cnt counts in SEND only and saturates at 0xFFFFFFFF.
- Asserting rst mid-packet drops the stream immediately (DMA reset is the system's responsibility).

Decomposition:
- Package axis_pg_pkg holds:
  - the state enum (IDLE, SEND, GAP, DONE);
  - the mode encodings;
  - LFSR_POLY = 32'h80200003;
  - the pattern step function.
- Sub-module axis_pg_pattern: 32-bit pattern register with load/advance controls and lane replication. The FSM, counters and handshake stay in the top.

Test Plan:
- Counter, len=128, num=2, gap=0, seed=0, tready=1 → 256 beats with tdata 0..255; tlast on beats 127 and 255; done=1; pkt_cnt=2; stall_cnt=0.
- Same config with tready toggling 1/0 → identical data/tlast sequence; each stalled beat held stable; stall_cnt equals the number of tready=0 cycles while tvalid=1.
- LFSR, seed=0, len=4, num=1 → first beat 1, then the Galois successors of 0x80200003; 4 beats; tlast on beat 3.
- Walking-one, seed=31, len=3, gap=5, num=2 → data 0x80000000, 0x1, 0x2 | 5 idle cycles | 0x4, 0x8, 0x10.
- Continuous counter, len=8; drop enable at beat 3 → beats 4..7 still sent; tlast on beat 7; then IDLE with busy=0 and done=0.
- Assert rst at beat 2 of a packet → next cycle tvalid=0, pkt_cnt=0; a new start begins again at seed.
